mac_dot_seq: RTL and testbench
==============================

Name: mac_dot_seq

Overview:
- Job sequencer for the signed MAC datapath: runs one length-N dot product per job.
- Streams operand pairs from an upstream valid/ready source into the MAC, asserting clr on the first pair of each job.
- Drains the MAC output, captures the final accumulator and presents it on a result valid/ready port.
- Sits between the operand fetch logic and the MAC; one MAC per sequencer.

Parameters:
- IN_BITS, 14, operand width is IN_BITS+1 bits, signed
- OUT_BITS, IN_BITS, accumulator/result width is OUT_BITS+1 bits, signed
- LEN_BITS, 8, width of job length field

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_BITS  number of operand pairs in the job; sampled with start
- abort  in  1  synchronous job cancel
- busy  out  1  high in every state except IDLE
- op_valid  in  1  upstream operand pair valid
- op_ready  out  1  upstream operand pair accepted when op_valid & op_ready
- op_x, op_y  in  IN_BITS+1  signed operands
- mac_in_valid  out  1  to MAC data_in_valid
- mac_in_enable  in  1  from MAC data_in_enable
- mac_clr  out  1  to MAC clr
- mac_x, mac_y  out  IN_BITS+1  to MAC operand inputs; driven combinationally from op_x, op_y
- mac_out_valid  in  1  from MAC data_out_valid
- mac_out_enable  out  1  to MAC data_out_enable
- mac_accum  in  OUT_BITS+1  from MAC accumulator
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  OUT_BITS+1  registered dot-product result

Behaviour:
- Reset values (rstn low, async):
  - state IDLE, count 0, length register 0
  - res_valid 0, res_data 0, busy 0
  - op_ready 0, mac_in_valid 0, mac_clr 0, mac_out_enable 0
- IDLE:
  - start=1 with len>0: latch len, count<=0, go to RUN.
  - start=1 with len=0: res_data<=0, go to DONE; no MAC traffic.
- RUN:
  - mac_in_valid=op_valid; op_ready=mac_in_enable; mac_clr=(count==0); mac_out_enable=1.
  - Transfer occurs when op_valid & mac_in_enable; each transfer increments count.
  - The transfer with count==len-1 moves the block to DRAIN.
  - No transfer: count and state hold. op_valid may stall arbitrarily.
- DRAIN:
  - op_ready=0, mac_in_valid=0, mac_out_enable=1.
  - First cycle with mac_out_valid=1: res_data<=mac_accum, go to DONE.
- DONE:
  - res_valid=1, mac_out_enable=0, op_ready=0.
  - res_ready=1: go to IDLE, res_valid drops next cycle.
- Latency: with continuous op_valid and mac_in_enable, start at cycle 0 gives transfers on cycles 1..N, capture on cycle N+1, res_valid high from cycle N+2.
- start while not IDLE: ignored; len is not re-latched.
- abort=1:
  - Any state goes to IDLE next cycle; res_valid and busy clear, count clears.
  - The in-progress pair in the abort cycle is not accepted: op_ready=0 whenever abort=1.
  - Abort has priority over start and over res_ready.
  - MAC state is left as is; the next job's mac_clr discards it.
- Arithmetic: the sequencer performs no arithmetic on data. Accumulator overflow wraps modulo 2^(OUT_BITS+1) inside the MAC; res_data is a bit-exact copy of mac_accum.
- Count width is LEN_BITS; len=2^LEN_BITS-1 is the maximum job and must not wrap early.
- Only one job in flight. A new start is accepted the cycle after the result handshake at the earliest.

Test Plan:
- Basic job: len=3, pairs (3,4),(-2,5),(7,1), op_valid continuous, res_ready=1.
  - Expected: mac_clr only on the first transfer; res_data=9; res_valid high at cycle 5 after start; busy low the cycle after the handshake.
- Back-to-back jobs: job A as in the basic job, then job B len=2 with pairs (1,1),(2,2).
  - Expected: res_data=5, not 14, confirming clr on B's first pair.
- Stalls: same as the basic job with op_valid toggling 1,0,0,1,0,1 and mac_in_enable forced low for 2 cycles mid-job.
  - Expected: exactly 3 transfers, no duplicates or drops; res_data=9.
- Result backpressure: res_ready=0 for 5 cycles after res_valid.
  - Expected: res_valid and res_data hold stable; a start during DONE is ignored; IDLE is reached after res_ready=1.
- Zero length and abort:
  - len=0: res_valid the cycle after start with res_data=0 and no mac_in_valid.
  - len=4 aborted after 2 transfers: IDLE next cycle, no res_valid; a following len=1 job with (-8,8) gives res_data=-64.
- Max length with overflow: len=255, every pair (16383,16383).
  - Expected: 255 transfers; res_data equals the wrapped 15-bit MAC value computed by the reference model.

Source files
------------

// File: rtl/mac_dot_seq.sv
// Job sequencer for a signed MAC: streams one length-N dot product per job into
// the MAC, then captures the final accumulator and offers it on a valid/ready port.
module mac_dot_seq #(
  parameter int IN_BITS  = 14,
  parameter int OUT_BITS = IN_BITS,
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [LEN_BITS-1:0] len,
  input  logic                abort,
  output logic                busy,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [IN_BITS:0]    op_x,
  input  logic [IN_BITS:0]    op_y,
  output logic                mac_in_valid,
  input  logic                mac_in_enable,
  output logic                mac_clr,
  output logic [IN_BITS:0]    mac_x,
  output logic [IN_BITS:0]    mac_y,
  input  logic                mac_out_valid,
  output logic                mac_out_enable,
  input  logic [OUT_BITS:0]   mac_accum,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OUT_BITS:0]   res_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic [LEN_BITS-1:0] count;
  logic [LEN_BITS-1:0] len_reg;
  logic                in_run;
  logic                xfer;
  logic                last_xfer;

  // The handshake passes straight through to the MAC; abort blocks the pair
  // in flight so neither side sees a transfer in the cancel cycle.
  assign in_run       = (state == RUN);
  assign op_ready     = in_run && mac_in_enable && !abort;
  assign mac_in_valid = in_run && op_valid && !abort;
  assign xfer         = in_run && op_valid && mac_in_enable && !abort;
  assign last_xfer    = xfer && (count == len_reg - LEN_BITS'(1));
  assign mac_x        = op_x;
  assign mac_y        = op_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      count          <= '0;
      len_reg        <= '0;
      busy           <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      mac_clr        <= 1'b0;
      mac_out_enable <= 1'b0;
    end else if (abort) begin
      // MAC contents are left alone; the next job's clr discards them.
      state          <= IDLE;
      count          <= '0;
      busy           <= 1'b0;
      res_valid      <= 1'b0;
      mac_clr        <= 1'b0;
      mac_out_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              len_reg        <= len;
              count          <= '0;
              mac_clr        <= 1'b1;
              mac_out_enable <= 1'b1;
              state          <= RUN;
            end else begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            count   <= count + LEN_BITS'(1);
            mac_clr <= 1'b0;
            if (last_xfer) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (mac_out_valid) begin
            res_data       <= mac_accum;
            res_valid      <= 1'b1;
            mac_out_enable <= 1'b0;
            state          <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural one-cycle MAC in the loop;
// table-driven jobs plus hand-written abort and max-length sequences.
module tb_mac_dot_seq;
  localparam int IN_BITS  = 14;
  localparam int OUT_BITS = 14;
  localparam int LEN_BITS = 8;

  logic                       clk = 1'b0;
  logic                       rstn;
  logic                       start;
  logic [LEN_BITS-1:0]        len;
  logic                       abort;
  logic                       busy;
  logic                       op_valid;
  logic                       op_ready;
  logic signed [IN_BITS:0]    op_x;
  logic signed [IN_BITS:0]    op_y;
  logic                       mac_in_valid;
  logic                       mac_in_enable;
  logic                       mac_clr;
  logic signed [IN_BITS:0]    mac_x;
  logic signed [IN_BITS:0]    mac_y;
  logic                       mac_out_valid;
  logic                       mac_out_enable;
  logic signed [OUT_BITS:0]   mac_accum;
  logic                       res_valid;
  logic                       res_ready;
  logic [OUT_BITS:0]          res_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .LEN_BITS(LEN_BITS)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .len           (len),
    .abort         (abort),
    .busy          (busy),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_x          (op_x),
    .op_y          (op_y),
    .mac_in_valid  (mac_in_valid),
    .mac_in_enable (mac_in_enable),
    .mac_clr       (mac_clr),
    .mac_x         (mac_x),
    .mac_y         (mac_y),
    .mac_out_valid (mac_out_valid),
    .mac_out_enable(mac_out_enable),
    .mac_accum     (mac_accum),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data)
  );

  // Behavioural MAC: accumulates on each accepted pair, output valid one cycle later.
  logic signed [OUT_BITS:0]       acc;
  logic                           out_pend;
  logic signed [2*IN_BITS+1:0]    prod;
  assign prod          = mac_x * mac_y;
  assign mac_accum     = acc;
  assign mac_out_valid = out_pend && mac_out_enable;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc      <= '0;
      out_pend <= 1'b0;
    end else begin
      out_pend <= mac_in_valid && mac_in_enable;
      if (mac_in_valid && mac_in_enable)
        acc <= (mac_clr ? '0 : acc) + prod[OUT_BITS:0];
    end
  end

  typedef struct {
    int         n;
    int         base;
    logic [7:0] vpat;
    int         en_low_at;
    int         rr_hold;
    bit         sid;
    int         exp_res;
    int         exp_lat;
  } vec_t;

  vec_t                    vecs[5];
  int                      pair_x[6];
  int                      pair_y[6];
  logic signed [IN_BITS:0] px[256];
  logic signed [IN_BITS:0] py[256];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input int n, input logic [7:0] vpat, input int en_low_at,
                         input int rr_hold, input bit sid,
                         output int lat, output int nx, output int nm,
                         output int clr_err, output int hold_err,
                         output logic signed [OUT_BITS:0] res);
    int cyc;
    int idx;
    bit done;
    cyc = 0; idx = 0; done = 0;
    lat = -1; nx = 0; nm = 0; clr_err = 0; hold_err = 0; res = '0;
    start = 1'b1;
    len   = LEN_BITS'(n);
    while (!done && cyc < 2000) begin
      if (cyc > 0) start = sid && (lat >= 0) && (cyc == lat + 1);
      op_valid      = (cyc >= 1) && vpat[(cyc - 1) % 8] && (idx < ((n == 0) ? 1 : n));
      op_x          = px[idx];
      op_y          = py[idx];
      mac_in_enable = !(en_low_at > 0 && cyc >= en_low_at && cyc < en_low_at + 2);
      res_ready     = (rr_hold == 0) || (lat >= 0 && cyc >= lat + rr_hold);
      @(negedge clk);
      if (mac_in_valid && mac_in_enable) nm++;
      if (op_valid && op_ready) begin
        nx++;
        if (mac_clr != (idx == 0)) clr_err++;
        idx++;
      end
      if (lat < 0 && res_valid) begin
        lat = cyc;
        res = res_data;
      end else if (lat >= 0 && (!res_valid || res_data != res)) begin
        hold_err++;
      end
      if (res_valid && res_ready) done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0; op_valid = 1'b0; res_ready = 1'b0; mac_in_enable = 1'b1;
    if (!done) chk("job_timeout", 1, 0);
  endtask

  int                       lat, nx, nm, clr_err, hold_err, bad;
  logic signed [OUT_BITS:0] res;
  logic signed [OUT_BITS:0] ref_acc;

  initial begin
    pair_x = '{3, -2, 7, 1, 2, -8};
    pair_y = '{4,  5, 1, 1, 2,  8};
    //          n  base vpat        en_low rr  sid res lat
    vecs[0] = '{3, 0,   8'hff,      0,     0,  0,  9,  5};  // basic job A
    vecs[1] = '{2, 3,   8'hff,      0,     0,  0,  5,  4};  // job B right after A
    vecs[2] = '{3, 0,   8'b11101001, 4,    0,  0,  9,  9};  // op_valid / enable stalls
    vecs[3] = '{3, 0,   8'hff,      0,     5,  1,  9,  5};  // result backpressure
    vecs[4] = '{0, 0,   8'hff,      0,     0,  0,  0,  1};  // zero length

    rstn = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
    op_valid = 1'b1; mac_in_enable = 1'b1; op_x = '0; op_y = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_mac_in_valid", mac_in_valid, 0);
    chk("rst_mac_clr", mac_clr, 0);
    chk("rst_mac_out_enable", mac_out_enable, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1; op_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        px[i] = (IN_BITS + 1)'(pair_x[vecs[v].base + i]);
        py[i] = (IN_BITS + 1)'(pair_y[vecs[v].base + i]);
      end
      run_job(vecs[v].n, vecs[v].vpat, vecs[v].en_low_at, vecs[v].rr_hold, vecs[v].sid,
              lat, nx, nm, clr_err, hold_err, res);
      $display("job %0d: len=%0d res=%0d lat=%0d xfers=%0d", v, vecs[v].n, res, lat, nx);
      chk($sformatf("v%0d_res", v), longint'(res), vecs[v].exp_res);
      chk($sformatf("v%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_op_xfers", v), nx, vecs[v].n);
      chk($sformatf("v%0d_mac_xfers", v), nm, vecs[v].n);
      chk($sformatf("v%0d_clr_pattern", v), clr_err, 0);
      chk($sformatf("v%0d_res_hold", v), hold_err, 0);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", v), busy, 0);
      chk($sformatf("v%0d_valid_after", v), res_valid, 0);
      @(posedge clk);
      #1;
    end

    // Abort a len=4 job after two transfers, with a pair offered in the abort cycle.
    for (int i = 0; i < 4; i++) begin
      px[i] = 15'sd2;
      py[i] = 15'sd3;
    end
    nx = 0;
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      op_valid = 1'b1; op_x = px[c]; op_y = py[c];
      @(negedge clk);
      if (op_valid && op_ready) nx++;
      @(posedge clk); #1;
    end
    chk("abort_pre_xfers", nx, 2);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_op_ready", op_ready, 0);
    chk("abort_mac_in_valid", mac_in_valid, 0);
    chk("abort_busy_during", busy, 1);
    @(posedge clk); #1;
    abort = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_next", busy, 0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (res_valid || busy) bad++;
    end
    chk("abort_stays_idle", bad, 0);
    @(posedge clk); #1;
    $display("job abort: len=4 aborted after %0d xfers", nx);

    px[0] = -15'sd8; py[0] = 15'sd8;
    run_job(1, 8'hff, 0, 0, 1'b0, lat, nx, nm, clr_err, hold_err, res);
    $display("job post_abort: len=1 res=%0d lat=%0d xfers=%0d", res, lat, nx);
    chk("post_abort_res", longint'(res), -64);
    chk("post_abort_lat", lat, 3);
    chk("post_abort_clr", clr_err, 0);
    @(posedge clk); #1;

    // Maximum length: each 16383*16383 product is 1 modulo 2^15, so the sum wraps to 255.
    ref_acc = '0;
    for (int i = 0; i < 255; i++) begin
      px[i] = 15'sd16383;
      py[i] = 15'sd16383;
      ref_acc = ref_acc + 15'(30'sd16383 * 30'sd16383);
    end
    run_job(255, 8'hff, 0, 0, 1'b0, lat, nx, nm, clr_err, hold_err, res);
    $display("job max: len=255 res=%0d lat=%0d xfers=%0d", res, lat, nx);
    chk("max_res_model", longint'(res), longint'(ref_acc));
    chk("max_res_const", longint'(res), 255);
    chk("max_xfers", nx, 255);
    chk("max_lat", lat, 257);
    chk("max_clr", clr_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
